// File: rtl/lfsr_sequence_controller.sv
// lfsr_sequence_controller
//   Command-driven sequencer around a W-bit Fibonacci LFSR. A SEED command
//   loads the LFSR (a zero seed is replaced by DEFAULT_SEED so the register
//   can never lock up at all-zero). A RUN command steps the LFSR N times,
//   streaming each pre-step state on a valid/ready output with full
//   backpressure. An abort ends a run early; done/aborted pulse on exit.
//
// Optional build macro: LFSR_PERIOD_CHECK_EN
//   When defined, the start state of each RUN is captured and period_hit
//   pulses the cycle after a step that lands back on that state. When not
//   defined, period_hit is tied to 0 and no capture register exists.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready : command handshake; accepted only while idle
//   cmd_op          : 0 = SEED, 1 = RUN
//   cmd_seed        : seed value (SEED only)
//   cmd_count       : step count N (RUN only)
//   abort           : terminate the run in progress
//   out_valid/ready : output stream handshake; out_data = current LFSR state
//   busy            : controller not idle
//   done, aborted   : one-cycle end-of-run pulses (aborted coincides with done)
//   seed_fixup      : one-cycle pulse after a zero seed was substituted
//   period_hit      : one-cycle pulse after a full LFSR period (optional)
module lfsr_sequence_controller #(
  parameter int             W            = 3,
  parameter logic [W-1:0]   TAPS         = 'b011,
  parameter logic [W-1:0]   DEFAULT_SEED = 'b001,
  parameter int             CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [W-1:0]     cmd_seed,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             seed_fixup,
  output logic             period_hit
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [W-1:0]     lfsr;
  logic [CNT_W-1:0] remaining;
  logic [W-1:0]     lfsr_nxt;
  logic             step;
  logic             run_acc;

  // Feedback enters at the MSB; the register shifts toward bit 0.
  assign lfsr_nxt  = {^(lfsr & TAPS), lfsr[W-1:1]};

  assign cmd_ready = (state == S_IDLE) && rst;
  assign out_valid = (state == S_RUN);
  assign out_data  = lfsr;
  assign busy      = (state != S_IDLE);
  assign step      = out_valid && out_ready;
  assign run_acc   = (state == S_IDLE) && cmd_valid && cmd_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lfsr       <= DEFAULT_SEED;
      remaining  <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      seed_fixup <= 1'b0;
    end else begin
      done       <= 1'b0;
      aborted    <= 1'b0;
      seed_fixup <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (!cmd_op) begin
              lfsr       <= (cmd_seed == '0) ? DEFAULT_SEED : cmd_seed;
              seed_fixup <= (cmd_seed == '0);
            end else if (cmd_count == '0) begin
              // Empty run: straight to the end-of-run cycle, no beats.
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              remaining <= cmd_count;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // A beat handshaken in the abort cycle still completes.
          if (out_ready) begin
            lfsr      <= lfsr_nxt;
            remaining <= remaining - CNT_W'(1);
          end
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (out_ready && remaining == CNT_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LFSR_PERIOD_CHECK_EN
  logic [W-1:0] start_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_state <= DEFAULT_SEED;
      period_hit  <= 1'b0;
    end else begin
      if (run_acc) start_state <= lfsr;
      period_hit <= step && (lfsr_nxt == start_state);
    end
  end
`else
  assign period_hit = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_sequence_controller.sv
// Randomized self-checking bench for lfsr_sequence_controller (default
// parameters). The reference model tracks the LFSR as an integer, advances it
// arithmetically, and predicts beats, done/aborted and period_hit per run.
module tb_lfsr_sequence_controller;
  localparam int W     = 3;
  localparam int CNT_W = 8;
  localparam int TAPS  = 3;
  localparam int DSEED = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_op;
  logic [W-1:0]     cmd_seed;
  logic [CNT_W-1:0] cmd_count;
  logic             abort, out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic             busy, done, aborted, seed_fixup, period_hit;

  int n_tests = 0;
  int n_fail  = 0;
  int m_lfsr;

  lfsr_sequence_controller dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_seed(cmd_seed), .cmd_count(cmd_count),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .aborted(aborted),
    .seed_fixup(seed_fixup), .period_hit(period_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next state: parity of tapped bits becomes the new MSB, rest shift down.
  function automatic int nxt(input int s);
    int p;
    p = $countones(s & TAPS) % 2;
    return (p << (W - 1)) + (s / 2);
  endfunction

  task automatic do_seed(input int s);
    @(negedge clk);
    chk("seed_rdy", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_seed = W'(s);
    @(negedge clk);
    cmd_valid = 1'b0;
    m_lfsr = (s == 0) ? DSEED : s;
    chk("seed_fixup", int'(seed_fixup), int'(s == 0));
    chk("seed_lfsr", int'(out_data), m_lfsr);
    @(negedge clk);
    chk("fixup_pulse", int'(seed_fixup), 0);
  endtask

  // rdy_pct: chance of out_ready per cycle; ab_at: abort with that handshake
  // (0 = never); noise: random ignored commands while the run is active.
  task automatic do_run(input int n, input int ab_at, input int rdy_pct, input bit noise);
    int  start, hs, cyc, exp_hs;
    bit  got_done, ph_next, exp_ab;
    @(negedge clk);
    chk("run_rdy", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_count = CNT_W'(n);
    start = m_lfsr; hs = 0; cyc = 0; got_done = 0; ph_next = 0;
    exp_ab = (ab_at > 0) && (ab_at <= n);
    exp_hs = exp_ab ? ab_at : n;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!got_done && cyc < 400) begin
      cyc++;
`ifdef LFSR_PERIOD_CHECK_EN
      chk("period_hit", int'(period_hit), int'(ph_next));
`else
      chk("period_hit", int'(period_hit), 0);
`endif
      if (done) begin
        got_done = 1;
        chk("aborted", int'(aborted), int'(exp_ab));
        chk("done_ovalid", int'(out_valid), 0);
        chk("done_busy", int'(busy), 1);
      end else begin
        chk("out_valid", int'(out_valid), 1);
        chk("out_data", int'(out_data), m_lfsr);
        chk("aborted_early", int'(aborted), 0);
        out_ready = ($urandom_range(99) < rdy_pct);
        abort = out_ready && (ab_at > 0) && (hs + 1 == ab_at);
        if (noise) begin
          cmd_valid = 1'($urandom); cmd_op = 1'($urandom);
          cmd_seed = W'($urandom); cmd_count = CNT_W'($urandom);
        end
        ph_next = 0;
        if (out_ready) begin
          m_lfsr = nxt(m_lfsr);
          hs++;
          ph_next = (m_lfsr == start);
        end
        @(negedge clk);
      end
    end
    abort = 1'b0; out_ready = 1'b0; cmd_valid = 1'b0;
    if (!got_done) chk("run_timeout", 0, 1);
    chk("beats", hs, exp_hs);
    if (rdy_pct >= 100) chk("latency", cyc, exp_hs + 1);
    @(negedge clk);
    chk("idle_rdy", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("done_pulse", int'(done), 0);
    chk("idle_lfsr", int'(out_data), m_lfsr);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_seed = '0;
    cmd_count = '0; abort = 1'b0; out_ready = 1'b0;
    m_lfsr = DSEED;
    repeat (2) @(negedge clk);
    chk("rst_rdy", int'(cmd_ready), 0);
    chk("rst_ovalid", int'(out_valid), 0);
    chk("rst_lfsr", int'(out_data), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_fixup", int'(seed_fixup), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ph", int'(period_hit), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", int'(cmd_ready), 1);

    do_run(3, 0, 100, 0);
    chk("run3_end", int'(out_data), 5);
    do_seed(4);
    do_run(8, 0, 100, 0);
    chk("run8_wrap", int'(out_data), 2);
    do_seed(0);
    chk("fix_lfsr", int'(out_data), 1);
    do_run(1, 0, 100, 0);
    do_run(4, 0, 50, 0);
    do_seed(1);
    do_run(10, 3, 100, 0);
    chk("abort_lfsr", int'(out_data), 5);
    do_run(0, 0, 100, 0);
    chk("n0_lfsr", int'(out_data), 5);

    // Reset in the middle of a run.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_count = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ovalid", int'(out_valid), 0);
    chk("mid_rst_lfsr", int'(out_data), 1);
    chk("mid_rst_busy", int'(busy), 0);
    m_lfsr = DSEED;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(out_valid), 0);
    end
    out_ready = 1'b0;
    chk("post_rst_hold", int'(out_data), 1);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(2) == 0) do_seed(int'($urandom_range(7)));
      do_run(int'($urandom_range(20)),
             ($urandom_range(2) == 0) ? int'($urandom_range(1, 12)) : 0,
             int'($urandom_range(30, 100)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_sequence_controller.md
Name: lfsr_sequence_controller

Overview:
- Command-driven sequencer wrapped around a W-bit Fibonacci LFSR.
- Accepts SEED and RUN commands over a valid/ready interface, then steps the LFSR exactly N times.
- Streams each pre-step state out on a valid/ready output, with full backpressure.
- Sits between a test/PRBS client and the pseudo-random datapath; blocks all-zero lockup seeds.

Parameters:
W, 3, LFSR width (>=2)
TAPS, 3'b011, feedback mask; next = {^(lfsr & TAPS), lfsr[W-1:1]}
DEFAULT_SEED, 3'b001, reset value and substitute for a zero seed (must be nonzero)
CNT_W, 8, width of step count

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  1  0 = SEED, 1 = RUN
cmd_seed  input  W  seed value (SEED only)
cmd_count  input  CNT_W  step count N (RUN only)
abort  input  1  terminate the RUN in progress
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  W  current LFSR state
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse at end of RUN
aborted  output  1  one-cycle pulse, coincident with done, if the RUN was aborted
seed_fixup  output  1  one-cycle pulse: zero seed was replaced

Behaviour:
- Reset (rst=0, async): FSM=IDLE, lfsr=DEFAULT_SEED, remaining=0; done, aborted, seed_fixup = 0. cmd_ready is high while in IDLE with reset released. Reset mid-RUN discards the run; nothing is emitted afterwards.
- States: IDLE, RUN, DONE.
- cmd_ready = (FSM==IDLE). out_valid = (FSM==RUN). out_data = lfsr, always. busy = (FSM!=IDLE).
- IDLE, on cmd_valid & cmd_op=0 (SEED):
  - lfsr <= cmd_seed, or DEFAULT_SEED if cmd_seed==0.
  - seed_fixup pulses the next cycle when the seed was substituted.
  - FSM stays in IDLE.
- IDLE, on cmd_valid & cmd_op=1 (RUN):
  - N==0: go to DONE, no output beats.
  - Otherwise: remaining <= N, go to RUN.
- RUN, each cycle with out_valid & out_ready:
  - lfsr <= next(lfsr); remaining <= remaining-1.
  - If remaining==1, go to DONE.
  - With out_ready=0, lfsr and out_data hold stable.
- RUN, abort=1:
  - Go to DONE and flag aborted.
  - If abort coincides with a handshake, that beat completes: the step happens and is counted. Abort takes priority over the normal transition.
- DONE: one cycle. done=1, aborted=1 if flagged. Then return to IDLE.
- Total beats for a RUN of N = N, unless aborted. The first beat equals the state at command acceptance.
- Throughput: 1 beat/cycle with out_ready held high. Latency: first out_valid in the cycle after RUN acceptance.
- The LFSR never enters all-zero: the seed is guarded, and with a nonzero state the shift cannot reach zero for a valid TAPS.
- The state wraps naturally after the period (7 for the defaults); the controller does not restart it.
- Command fields are sampled only on acceptance. cmd_valid outside IDLE is ignored, with no side effects.

Optional Feature:
- Macro: LFSR_PERIOD_CHECK_EN.
- Defined:
  - Adds output period_hit (1 bit), reset 0.
  - On RUN acceptance, the start state is captured.
  - period_hit pulses one cycle after any step whose new lfsr equals the captured start state, i.e. a full period was completed.
- Not defined:
  - The port exists, tied to 0.
  - No capture register is built.

Test Plan:
- Reset, then RUN N=3 with out_ready=1 -> out_data beats 001,100,010. done pulses the cycle after the last beat. lfsr ends at 101. cmd_ready returns to 1.
- SEED 100, then RUN N=8 -> beats 100,010,101,110,111,011,001,100 (wrap). With LFSR_PERIOD_CHECK_EN, period_hit pulses once, after the 7th step.
- SEED 000 -> seed_fixup pulses once and lfsr=001. A following RUN N=1 emits 001.
- RUN N=4 with out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 beats (001,100,010,101), out_data held stable during stalls, done after the 4th handshake.
- RUN N=10, abort asserted together with the 3rd handshake -> 3 beats emitted, then done and aborted pulse together. lfsr=101 (3 steps taken from 001).
- Reset asserted mid-RUN, or RUN N=0 -> reset: out_valid drops immediately, lfsr=001. N=0: no beats, done pulses the next cycle, lfsr unchanged.
